// File: rtl/board_cursor_ctrl.sv
// 8x8 board cursor and two-step (source, destination) move request driven by debounced button pulses.
// Define CURSOR_WRAP_EN to make the cursor wrap modulo 8; otherwise it saturates at the board edges.
module board_cursor_ctrl #(
    parameter logic [2:0] INIT_ROW    = 3'd1,
    parameter logic [2:0] INIT_COL    = 3'd4,
    parameter int         TIMEOUT_CYC = 244000,
    parameter int         TW          = 18
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       BtnU_pulse,
    input  logic       BtnD_pulse,
    input  logic       BtnL_pulse,
    input  logic       BtnR_pulse,
    input  logic       BtnC_pulse,
    output logic [2:0] Cursor_row,
    output logic [2:0] Cursor_col,
    output logic       Src_valid,
    output logic [5:0] Src_sq,
    output logic       Move_valid,
    output logic [5:0] Move_src,
    output logic [5:0] Move_dst,
    input  logic       Move_ready
);

    typedef enum logic [1:0] {S_IDLE, S_SRC_HELD, S_MOVE_OUT} state_t;

    localparam logic [TW-1:0] CNT_LAST = TW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [2:0]  row_q, row_d, col_q, col_d;
    logic        src_valid_q, src_valid_d;
    logic [5:0]  src_sq_q, src_sq_d;
    logic        move_valid_q, move_valid_d;
    logic [5:0]  move_src_q, move_src_d, move_dst_q, move_dst_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic       any_pulse, sel_same, timeout_hit;
    logic [5:0] cursor_sq;

    // Opposing pulses cancel; edge behaviour depends on the wrap build option.
    function automatic logic [2:0] step_axis(input logic [2:0] v, input logic inc, input logic dec);
        logic [2:0] r;
        r = v;
        if (inc && !dec) begin
`ifdef CURSOR_WRAP_EN
            r = v + 3'd1;
`else
            if (v != 3'd7) r = v + 3'd1;
`endif
        end else if (dec && !inc) begin
`ifdef CURSOR_WRAP_EN
            r = v - 3'd1;
`else
            if (v != 3'd0) r = v - 3'd1;
`endif
        end
        return r;
    endfunction

    // Select compares against the pre-motion cursor, so same-cycle motion never affects it.
    assign cursor_sq   = {row_q, col_q};
    assign any_pulse   = BtnU_pulse | BtnD_pulse | BtnL_pulse | BtnR_pulse | BtnC_pulse;
    assign sel_same    = (cursor_sq == src_sq_q);
    assign timeout_hit = (TIMEOUT_CYC != 0) && !any_pulse && (cnt_q == CNT_LAST);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (BtnC_pulse) state_d = S_SRC_HELD;
            S_SRC_HELD: begin
                if (BtnC_pulse)       state_d = sel_same ? S_IDLE : S_MOVE_OUT;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_MOVE_OUT: if (move_valid_q && Move_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        row_d        = step_axis(row_q, BtnU_pulse, BtnD_pulse);
        col_d        = step_axis(col_q, BtnR_pulse, BtnL_pulse);
        src_valid_d  = src_valid_q;
        src_sq_d     = src_sq_q;
        move_valid_d = move_valid_q;
        move_src_d   = move_src_q;
        move_dst_d   = move_dst_q;
        cnt_d        = '0;
        case (state_q)
            S_IDLE: begin
                if (BtnC_pulse) begin
                    src_valid_d = 1'b1;
                    src_sq_d    = cursor_sq;
                end
            end
            S_SRC_HELD: begin
                if (BtnC_pulse || timeout_hit) begin
                    src_valid_d = 1'b0;
                    src_sq_d    = '0;
                    if (BtnC_pulse && !sel_same) begin
                        move_valid_d = 1'b1;
                        move_src_d   = src_sq_q;
                        move_dst_d   = cursor_sq;
                    end
                end else if (!any_pulse) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_MOVE_OUT: if (move_valid_q && Move_ready) move_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            row_q        <= INIT_ROW;
            col_q        <= INIT_COL;
            src_valid_q  <= 1'b0;
            src_sq_q     <= '0;
            move_valid_q <= 1'b0;
            move_src_q   <= '0;
            move_dst_q   <= '0;
            cnt_q        <= '0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            src_valid_q  <= src_valid_d;
            src_sq_q     <= src_sq_d;
            move_valid_q <= move_valid_d;
            move_src_q   <= move_src_d;
            move_dst_q   <= move_dst_d;
            cnt_q        <= cnt_d;
        end
    end

    assign Cursor_row = row_q;
    assign Cursor_col = col_q;
    assign Src_valid  = src_valid_q;
    assign Src_sq     = src_sq_q;
    assign Move_valid = move_valid_q;
    assign Move_src   = move_src_q;
    assign Move_dst   = move_dst_q;

endmodule
